// File: rtl/vote_collector.sv
// Vote collector: gathers one vote per voter inside a bounded window and
// presents the latched votes to the downstream majority block.
module vote_collector #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] vote_valid,
    input  logic [2:0] vote_val,
    output logic       v1,
    output logic       v2,
    output logic       v3,
    output logic [2:0] voted_mask,
    output logic       busy,
    output logic       votes_ready,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state_reg;
    logic [2:0]      vote_reg;
    logic [2:0]      mask_reg;
    logic [TO_W-1:0] timer_reg;
    logic            busy_reg;
    logic            ready_reg;
    logic            timeout_reg;

    logic [2:0]      capture;
    logic [2:0]      vote_next;
    logic [2:0]      mask_next;

    // Only voters without a captured vote may latch; first vote wins.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_capture
            assign capture[gi]   = vote_valid[gi] & ~mask_reg[gi];
            assign vote_next[gi] = capture[gi] ? vote_val[gi] : vote_reg[gi];
            assign mask_next[gi] = mask_reg[gi] | vote_valid[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            vote_reg    <= 3'b000;
            mask_reg    <= 3'b000;
            timer_reg   <= '0;
            busy_reg    <= 1'b0;
            ready_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_COLLECT: begin
                    vote_reg <= vote_next;
                    mask_reg <= mask_next;
                    // Completion takes priority over expiry on the last cycle.
                    if (mask_next == 3'b111) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                    end else if (timer_reg == TIMER_LAST) begin
                        state_reg   <= ST_TIMEOUT;
                        busy_reg    <= 1'b0;
                        ready_reg   <= 1'b1;
                        timeout_reg <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        state_reg   <= ST_COLLECT;
                        vote_reg    <= 3'b000;
                        mask_reg    <= 3'b000;
                        timer_reg   <= '0;
                        busy_reg    <= 1'b1;
                        ready_reg   <= 1'b0;
                        timeout_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign v1          = vote_reg[0];
    assign v2          = vote_reg[1];
    assign v3          = vote_reg[2];
    assign voted_mask  = mask_reg;
    assign busy        = busy_reg;
    assign votes_ready = ready_reg;
    assign timeout     = timeout_reg;

endmodule

// File: tb/tb_vote_collector.sv
// Bench for vote_collector: directed scenarios plus random traffic, compared
// against a window/ballot model evaluated once per clock.
module tb_vote_collector;

    localparam int TIMEOUT_CYCLES = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] vote_valid;
    logic [2:0] vote_val;
    logic       v1, v2, v3;
    logic [2:0] voted_mask;
    logic       busy, votes_ready, timeout;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: is a window open, how many cycles it has run,
    // which ballots arrived and what they said, and how it ended.
    bit       m_open;
    int       m_elapsed;
    bit [2:0] m_got;
    bit [2:0] m_vote;
    bit       m_ready;
    bit       m_to;

    vote_collector #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .vote_valid(vote_valid), .vote_val(vote_val),
        .v1(v1), .v2(v2), .v3(v3), .voted_mask(voted_mask),
        .busy(busy), .votes_ready(votes_ready), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_open = 0; m_elapsed = 0; m_got = 0; m_vote = 0; m_ready = 0; m_to = 0;
    endtask

    task automatic model_step(input logic s, input logic [2:0] vv, input logic [2:0] vl);
        if (!m_open) begin
            if (s) begin
                m_open = 1; m_elapsed = 0; m_got = 0; m_vote = 0; m_ready = 0; m_to = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++)
                if (vv[i] && !m_got[i]) begin
                    m_got[i]  = 1'b1;
                    m_vote[i] = vl[i];
                end
            m_elapsed++;
            if (m_got == 3'b111) begin
                m_open = 0; m_ready = 1;
            end else if (m_elapsed == TIMEOUT_CYCLES) begin
                m_open = 0; m_ready = 1; m_to = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".votes"}, {v3, v2, v1}, m_vote);
        chk({tag, ".mask"}, voted_mask, m_got);
        chk({tag, ".busy"}, {2'b00, busy}, {2'b00, m_open});
        chk({tag, ".ready"}, {2'b00, votes_ready}, {2'b00, m_ready});
        chk({tag, ".timeout"}, {2'b00, timeout}, {2'b00, m_to});
    endtask

    // Called at a negedge: apply inputs, let one rising edge pass, check.
    task automatic tick(input string tag, input logic s, input logic [2:0] vv, input logic [2:0] vl);
        start = s; vote_valid = vv; vote_val = vl;
        @(posedge clk);
        model_step(s, vv, vl);
        @(negedge clk);
        check_all(tag);
        $display("tick %-10s start=%b valid=%b val=%b -> v=%b%b%b mask=%b busy=%b ready=%b to=%b",
                 tag, s, vv, vl, v3, v2, v1, voted_mask, busy, votes_ready, timeout);
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        $display("async reset %s -> mask=%b busy=%b ready=%b", tag, voted_mask, busy, votes_ready);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 0; vote_valid = 0; vote_val = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        tick("idle", 0, 3'b111, 3'b111);

        // All three voters in one cycle.
        tick("start", 1, 0, 0);
        tick("allvote", 0, 3'b111, 3'b101);
        chk("allvote.ready_const", {2'b00, votes_ready}, 3'b001);
        chk("allvote.votes_const", {v3, v2, v1}, 3'b101);

        // Staggered votes with a re-vote from voter1.
        tick("start2", 1, 0, 0);
        tick("c2", 0, 3'b001, 3'b001);
        tick("c3", 0, 3'b001, 3'b000);
        tick("c4", 0, 0, 0);
        tick("c5", 0, 3'b100, 3'b100);
        tick("c6", 0, 0, 0);
        chk("c6.not_ready", {2'b00, votes_ready}, 3'b000);
        tick("c7", 0, 3'b010, 3'b000);
        chk("c7.votes_const", {v3, v2, v1}, 3'b101);
        chk("c7.ready_const", {2'b00, votes_ready}, 3'b001);

        // DONE ignores strobes; start mid-window does not restart.
        tick("done_hold", 0, 3'b111, 3'b010);
        tick("start3", 1, 0, 0);
        chk("start3.mask_clear", voted_mask, 3'b000);
        tick("w_v2", 0, 3'b010, 3'b010);
        for (int k = 2; k <= TIMEOUT_CYCLES; k++)
            tick("to_wait", (k == 5) ? 1'b1 : 1'b0, 3'b000, 3'b000);
        chk("to.timeout_const", {2'b00, timeout}, 3'b001);
        chk("to.mask_const", voted_mask, 3'b010);
        chk("to.votes_const", {v3, v2, v1}, 3'b010);

        // Last vote lands exactly on the final timer cycle.
        tick("start4", 1, 0, 0);
        tick("b_v12", 0, 3'b011, 3'b011);
        for (int k = 0; k < TIMEOUT_CYCLES - 2; k++)
            tick("b_wait", 0, 0, 0);
        chk("b.still_busy", {2'b00, busy}, 3'b001);
        tick("b_v3", 0, 3'b100, 3'b000);
        chk("b.timeout_const", {2'b00, timeout}, 3'b000);
        chk("b.mask_const", voted_mask, 3'b111);

        // Asynchronous reset mid-window with two votes captured.
        tick("start5", 1, 0, 0);
        tick("r_v12", 0, 3'b011, 3'b011);
        chk("r.mask_pre", voted_mask, 3'b011);
        async_reset("midwin");
        chk("r.mask_const", voted_mask, 3'b000);

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            logic [2:0] vv;
            for (int b = 0; b < 3; b++) vv[b] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
            tick("rnd", ($urandom_range(0, 11) == 0), vv, 3'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
